// File: rtl/stopwatch_core_if.sv
// Stopwatch core signal bundle: debounced button/adjust controls in,
// BCD digits and status flags out. The master side (button logic or a
// testbench) drives the controls. The slave side (stopwatch_core)
// drives the display/status outputs.
// There is no valid/ready handshake here. The control inputs are
// sampled as levels on every clk edge. Every output is a registered
// value that is valid on every cycle. sec_tick and wrap are one-cycle
// pulses.
interface stopwatch_core_if;
    logic       pause_btn;
    logic       adj;
    logic       sel;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       adjusting;
    logic       sec_tick;
    logic       wrap;
    logic [1:0] state_dbg;

    modport master (
        output pause_btn, adj, sel,
        input  min_tens, min_ones, sec_tens, sec_ones,
        input  running, adjusting, sec_tick, wrap, state_dbg
    );

    modport slave (
        input  pause_btn, adj, sel,
        output min_tens, min_ones, sec_tens, sec_ones,
        output running, adjusting, sec_tick, wrap, state_dbg
    );
endinterface

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch with an internal seconds prescaler.
// A rising edge of pause_btn toggles between run and pause.
// When adj is held, the core presets minutes or seconds at the adjust rate.
// Optional macro STOPWATCH_SATURATE_EN: when defined, a RUN rollover past
// MIN_MAX:59 holds at MIN_MAX:59 and pauses, instead of wrapping to 00:00.
module stopwatch_core #(
    parameter int TICK_DIV = 100000000,
    parameter int ADJ_DIV  = 50000000,
    parameter int MIN_MAX  = 99
) (
    input  logic clk,
    input  logic rst,
    stopwatch_core_if.slave sw
);
    typedef enum logic [1:0] {PAUSED = 2'd0, RUN = 2'd1, ADJUST = 2'd2} state_t;

    localparam int PMAX = (TICK_DIV > ADJ_DIV) ? TICK_DIV : ADJ_DIV;
    localparam int PW   = $clog2(PMAX);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] ADJ_LAST  = PW'(ADJ_DIV - 1);
    localparam logic [PW-1:0] PONE      = PW'(1);
    localparam logic [3:0]    MAX_T     = 4'(MIN_MAX / 10);
    localparam logic [3:0]    MAX_O     = 4'(MIN_MAX % 10);

    state_t        state;
    logic [PW-1:0] presc;
    logic          pb_q;
    logic [3:0]    mt, mo, st, so;
    logic          tick_r, wrap_r;

    logic          pe;
    logic [3:0]    so_n, st_n, mo_n, mt_n;
    logic          sec_carry, min_roll;

    assign pe = sw.pause_btn & ~pb_q;

    // BCD +1 of the seconds field (59 -> 00) and of the minutes field (MIN_MAX -> 00)
    always_comb begin
        so_n      = so + 4'd1;
        st_n      = st;
        sec_carry = 1'b0;
        if (so == 4'd9) begin
            so_n = 4'd0;
            if (st == 4'd5) begin
                st_n      = 4'd0;
                sec_carry = 1'b1;
            end else begin
                st_n = st + 4'd1;
            end
        end
        mo_n     = mo + 4'd1;
        mt_n     = mt;
        min_roll = 1'b0;
        if (mt == MAX_T && mo == MAX_O) begin
            mo_n     = 4'd0;
            mt_n     = 4'd0;
            min_roll = 1'b1;
        end else if (mo == 4'd9) begin
            mo_n = 4'd0;
            mt_n = mt + 4'd1;
        end
    end

    // State machine, prescaler, digits and pulse flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= PAUSED;
            presc  <= '0;
            pb_q   <= sw.pause_btn;
            mt     <= 4'd0;
            mo     <= 4'd0;
            st     <= 4'd0;
            so     <= 4'd0;
            tick_r <= 1'b0;
            wrap_r <= 1'b0;
        end else begin
            pb_q   <= sw.pause_btn;
            tick_r <= 1'b0;
            wrap_r <= 1'b0;
            if (sw.adj) begin
                if (state != ADJUST) begin
                    // Entry: any coincident terminal increment is dropped
                    state <= ADJUST;
                    presc <= '0;
                end else if (presc == ADJ_LAST) begin
                    presc <= '0;
                    if (sw.sel) begin
                        mo <= mo_n;
                        mt <= mt_n;
                    end else begin
                        so <= so_n;
                        st <= st_n;
                    end
                end else begin
                    presc <= presc + PONE;
                end
            end else begin
                case (state)
                    ADJUST: begin
                        state <= PAUSED;
                        presc <= '0;
                    end
                    RUN: begin
                        if (presc == TICK_LAST) begin
                            presc  <= '0;
                            tick_r <= 1'b1;
                            if (sec_carry && min_roll) begin
                                wrap_r <= 1'b1;
`ifdef STOPWATCH_SATURATE_EN
                                state  <= PAUSED;
`else
                                so <= so_n;
                                st <= st_n;
                                mo <= mo_n;
                                mt <= mt_n;
`endif
                            end else begin
                                so <= so_n;
                                st <= st_n;
                                if (sec_carry) begin
                                    mo <= mo_n;
                                    mt <= mt_n;
                                end
                            end
                        end else begin
                            presc <= presc + PONE;
                        end
                        if (pe) state <= PAUSED;
                    end
                    default: begin
                        // PAUSED: prescaler holds the fractional second
                        if (pe) state <= RUN;
                    end
                endcase
            end
        end
    end

    assign sw.min_tens  = mt;
    assign sw.min_ones  = mo;
    assign sw.sec_tens  = st;
    assign sw.sec_ones  = so;
    assign sw.running   = (state == RUN);
    assign sw.adjusting = (state == ADJUST);
    assign sw.sec_tick  = tick_r;
    assign sw.wrap      = wrap_r;
    assign sw.state_dbg = state;
endmodule

// File: tb/tb_stopwatch_core.sv
// Testbench for stopwatch_core. It uses TICK_DIV=4, ADJ_DIV=2 and MIN_MAX=99.
// A time-in-seconds reference model is compared with the DUT on every cycle.
// Directed milestones follow the stopwatch behaviour, and a random phase follows them.
module tb_stopwatch_core;
    localparam int TICK_DIV = 4;
    localparam int ADJ_DIV  = 2;
    localparam int MIN_MAX  = 99;

    logic clk;
    logic rst;
    stopwatch_core_if sw();

    stopwatch_core #(.TICK_DIV(TICK_DIV), .ADJ_DIV(ADJ_DIV), .MIN_MAX(MIN_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_assert = 0;
    int n_fail   = 0;
    int n_ticks  = 0;

    // Reference model: mode 0 = paused, 1 = run, 2 = adjust
    int m_mode = 0;
    int m_pre  = 0;
    int m_min  = 0;
    int m_sec  = 0;
    bit m_pbq  = 0;
    bit m_tick = 0;
    bit m_wrap = 0;

    task automatic model_step();
        bit pe;
        int t;
        pe = sw.pause_btn && !m_pbq;
        if (rst) begin
            m_mode = 0; m_pre = 0; m_min = 0; m_sec = 0;
            m_tick = 0; m_wrap = 0; m_pbq = sw.pause_btn;
            return;
        end
        m_pbq  = sw.pause_btn;
        m_tick = 0;
        m_wrap = 0;
        if (sw.adj) begin
            if (m_mode != 2) begin
                m_mode = 2;
                m_pre  = 0;
            end else if (m_pre == ADJ_DIV - 1) begin
                m_pre = 0;
                if (sw.sel) m_min = (m_min + 1) % (MIN_MAX + 1);
                else        m_sec = (m_sec + 1) % 60;
            end else begin
                m_pre++;
            end
        end else if (m_mode == 2) begin
            m_mode = 0;
            m_pre  = 0;
        end else if (m_mode == 0) begin
            if (pe) m_mode = 1;
        end else begin
            if (m_pre == TICK_DIV - 1) begin
                m_pre  = 0;
                m_tick = 1;
                t = m_min * 60 + m_sec + 1;
                if (t == (MIN_MAX + 1) * 60) begin
                    m_wrap = 1;
`ifdef STOPWATCH_SATURATE_EN
                    t      = t - 1;
                    m_mode = 0;
`else
                    t = 0;
`endif
                end
                m_min = t / 60;
                m_sec = t % 60;
            end else begin
                m_pre++;
            end
            if (pe) m_mode = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] model_vec();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
                (m_mode == 1), (m_mode == 2), m_tick, m_wrap};
    endfunction

    function automatic logic [15:0] digits();
        return {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
    endfunction

    // One clock: model advances on the edge, outputs compared on the falling edge
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("cycle_model",
              {digits(), sw.running, sw.adjusting, sw.sec_tick, sw.wrap}, model_vec());
        if (sw.sec_tick) n_ticks++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press();
        sw.pause_btn = 1'b1;
        step();
        sw.pause_btn = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sw.pause_btn = 1'b0;
        sw.adj = 1'b0;
        sw.sel = 1'b0;
        run(2);
        rst = 1'b0;

        // Idle after reset
        n_ticks = 0;
        run(20);
        check("idle_digits", digits(), 16'h0000);
        check("idle_running", sw.running, 0);
        check("idle_ticks", n_ticks, 0);

        // Reset in the middle of RUN at 00:07
        press();
        run(28);
        check("run_0007", digits(), 16'h0007);
        check("run_0007_running", sw.running, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrun_rst_digits", digits(), 16'h0000);
        check("midrun_rst_running", sw.running, 0);

        // Count to 01:00 through the seconds carries
        press();
        n_ticks = 0;
        run(40);
        check("carry_0010", digits(), 16'h0010);
        run(200);
        check("carry_0100", digits(), 16'h0100);
        check("ticks_60", n_ticks, 60);

        // Pause two cycles into a second, and the fraction is kept across resume
        step();
        press();
        check("paused_running", sw.running, 0);
        run(50);
        check("paused_frozen", digits(), 16'h0100);
        check("paused_no_ticks", n_ticks, 60);
        press();
        check("resume_running", sw.running, 1);
        step();
        check("resume_tick_early", sw.sec_tick, 0);
        step();
        check("resume_tick_2", sw.sec_tick, 1);
        check("resume_0101", digits(), 16'h0101);

        // Adjust: the entry cycle, then 20 minute-adjust cycles, then 120 second-adjust cycles with ignored presses
        rst = 1'b1; step(); rst = 1'b0;
        sw.adj = 1'b1; sw.sel = 1'b1;
        step();
        run(20);
        check("adj_min_10", digits(), 16'h1000);
        check("adj_adjusting", sw.adjusting, 1);
        sw.sel = 1'b0;
        for (int i = 0; i < 120; i++) begin
            sw.pause_btn = ((i % 6) < 3);
            step();
        end
        sw.pause_btn = 1'b0;
        check("adj_sec_wrap_nocarry", digits(), 16'h1000);
        check("adj_pe_ignored", sw.running, 0);
        sw.adj = 1'b0;
        step();
        check("adj_exit_adjusting", sw.adjusting, 0);
        check("adj_exit_running", sw.running, 0);

        // Preset to 99:58, then run through the rollover
        rst = 1'b1; step(); rst = 1'b0;
        sw.adj = 1'b1; sw.sel = 1'b1;
        step();
        run(198);
        check("preset_min_99", digits(), 16'h9900);
        sw.sel = 1'b0;
        run(116);
        check("preset_9958", digits(), 16'h9958);
        sw.adj = 1'b0;
        step();
        press();
        run(4);
        check("roll_9959", digits(), 16'h9959);
        run(4);
        check("roll_wrap", sw.wrap, 1);
        check("roll_tick", sw.sec_tick, 1);
`ifdef STOPWATCH_SATURATE_EN
        check("sat_hold", digits(), 16'h9959);
        check("sat_running", sw.running, 0);
        step();
        check("sat_wrap_once", sw.wrap, 0);
        press();
        run(4);
        check("sat_hold_again", digits(), 16'h9959);
        check("sat_wrap_again", sw.wrap, 1);
        check("sat_paused_again", sw.running, 0);
`else
        check("roll_0000", digits(), 16'h0000);
        check("roll_running", sw.running, 1);
        step();
        check("roll_wrap_pulse", sw.wrap, 0);
`endif

        // Pause press on the terminal cycle at 00:03, then adj rising on a terminal cycle
        rst = 1'b1; step(); rst = 1'b0;
        press();
        run(12);
        check("coinc_0003", digits(), 16'h0003);
        run(3);
        press();
        check("coinc_pe_0004", digits(), 16'h0004);
        check("coinc_pe_paused", sw.running, 0);
        press();
        run(3);
        sw.adj = 1'b1;
        step();
        check("coinc_adj_dropped", digits(), 16'h0004);
        check("coinc_adj_state", sw.adjusting, 1);
        sw.adj = 1'b0;
        step();
        check("coinc_adj_exit", sw.adjusting, 0);
        press();
        run(3);
        check("presc_cleared_no_tick", sw.sec_tick, 0);
        check("presc_cleared_digits", digits(), 16'h0004);
        step();
        check("presc_cleared_tick", sw.sec_tick, 1);
        check("presc_cleared_0005", digits(), 16'h0005);

        // Random phase against the model
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) sw.pause_btn = ~sw.pause_btn;
            if ($urandom_range(0, 59) == 0) sw.adj = ~sw.adj;
            if ($urandom_range(0, 9) == 0)  sw.sel = ~sw.sel;
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
